// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 defaults), timing struct and helpers.
package vga_pkg;

    localparam int unsigned H_AREA_DEF = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned V_AREA_DEF = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;

    // One axis of a video timing: active area, front porch, sync, back porch
    typedef struct packed {
        logic [15:0] area;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    function automatic int unsigned timing_total(input vga_timing_t t);
        return 32'(t.area) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
    endfunction

    function automatic int unsigned sync_start(input vga_timing_t t);
        return 32'(t.area) + 32'(t.fp);
    endfunction

    function automatic int unsigned sync_end(input vga_timing_t t);
        return 32'(t.area) + 32'(t.fp) + 32'(t.sync);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_en_div.sv
// Pixel-rate divider: registered pixel strobe every PIXEL_DIV clocks while run is high.
module pixel_en_div #(
    parameter int unsigned PIXEL_DIV = 1
) (
    input  logic CLK_40,
    input  logic reset_n,
    input  logic run,
    output logic running,
    output logic pixel_en,
    output logic pixel_en_nxt_c
);

    localparam int unsigned CNT_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIXEL_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    // Counter restarts at 0 on the first running cycle so that cycle shows the origin
    always_comb begin
        cnt_nxt = '0;
        if (run && running) begin
            cnt_nxt = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
        pixel_en_nxt_c = run && (cnt_nxt == CNT_LAST);
    end

    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            running  <= 1'b0;
            pixel_en <= 1'b0;
        end else begin
            cnt_q    <= cnt_nxt;
            running  <= run;
            pixel_en <= pixel_en_nxt_c;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with zero-skew registered syncs and blanking.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned PIXEL_DIV = 1,
    parameter int unsigned H_AREA    = H_AREA_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned V_AREA    = V_AREA_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    localparam int unsigned H_TOTAL  = H_AREA + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_AREA + V_FP + V_SYNC + V_BP,
    localparam int unsigned X_W      = $clog2(H_TOTAL),
    localparam int unsigned Y_W      = $clog2(V_TOTAL)
) (
    input  logic           CLK_40,
    input  logic           reset_n,
    input  logic           run,
    output logic           pixel_en,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos,
    output logic           hsync,
    output logic           vsync,
    output logic           h_blank,
    output logic           v_blank,
    output logic           active,
    output logic           line_start,
    output logic           frame_start
);

    localparam vga_timing_t H_TIM = '{area: 16'(H_AREA), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam vga_timing_t V_TIM = '{area: 16'(V_AREA), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};

    localparam logic [X_W-1:0] X_LAST   = X_W'(timing_total(H_TIM) - 1);
    localparam logic [X_W-1:0] X_AREA   = X_W'(H_AREA);
    localparam logic [X_W-1:0] HS_START = X_W'(sync_start(H_TIM));
    localparam logic [X_W-1:0] HS_END   = X_W'(sync_end(H_TIM));
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(timing_total(V_TIM) - 1);
    localparam logic [Y_W-1:0] Y_AREA   = Y_W'(V_AREA);
    localparam logic [Y_W-1:0] VS_START = Y_W'(sync_start(V_TIM));
    localparam logic [Y_W-1:0] VS_END   = Y_W'(sync_end(V_TIM));

    logic           run_q;
    logic           running;
    logic           pe_nxt_c;
    logic [X_W-1:0] x_nxt;
    logic [Y_W-1:0] y_nxt;
    logic           hsync_nxt, vsync_nxt, h_blank_nxt, v_blank_nxt, active_nxt;
    logic           line_start_nxt, frame_start_nxt;

    pixel_en_div #(
        .PIXEL_DIV(PIXEL_DIV)
    ) u_div (
        .CLK_40        (CLK_40),
        .reset_n       (reset_n),
        .run           (run_q),
        .running       (running),
        .pixel_en      (pixel_en),
        .pixel_en_nxt_c(pe_nxt_c)
    );

    // Next raster position; all flags are decoded from it so they register alongside x/y
    always_comb begin
        x_nxt = '0;
        y_nxt = '0;
        if (run_q && running) begin
            x_nxt = x_pos;
            y_nxt = y_pos;
            if (pixel_en) begin
                if (x_pos == X_LAST) begin
                    x_nxt = '0;
                    y_nxt = (y_pos == Y_LAST) ? '0 : y_pos + Y_W'(1);
                end else begin
                    x_nxt = x_pos + X_W'(1);
                end
            end
        end
        h_blank_nxt     = !run_q || (x_nxt >= X_AREA);
        v_blank_nxt     = !run_q || (y_nxt >= Y_AREA);
        active_nxt      = !h_blank_nxt && !v_blank_nxt;
        hsync_nxt       = (run_q && x_nxt >= HS_START && x_nxt < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync_nxt       = (run_q && y_nxt >= VS_START && y_nxt < VS_END) ? VSYNC_POL : ~VSYNC_POL;
        line_start_nxt  = pe_nxt_c && (x_nxt == '0);
        frame_start_nxt = line_start_nxt && (y_nxt == '0);
    end

    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            run_q       <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            h_blank     <= 1'b1;
            v_blank     <= 1'b1;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            run_q       <= run;
            x_pos       <= x_nxt;
            y_pos       <= y_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            h_blank     <= h_blank_nxt;
            v_blank     <= v_blank_nxt;
            active      <= active_nxt;
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 16x8 raster (div 1, div 3, inverted polarity) plus the default 800x525 raster.
module tb_vga_timing_gen;

    logic CLK_40 = 1'b0;
    logic reset_n = 1'b0;
    logic run = 1'b0;

    always #5 CLK_40 = ~CLK_40;

    int n_cmp = 0;
    int n_err = 0;

    // a: small, div 1 | b: small, div 3 | c: small, polarity 1 | d: default 640x480
    logic       a_pe, a_hs, a_vs, a_hb, a_vb, a_act, a_ls, a_fs;
    logic [3:0] a_x;
    logic [2:0] a_y;
    logic       b_pe, b_hs, b_vs, b_hb, b_vb, b_act, b_ls, b_fs;
    logic [3:0] b_x;
    logic [2:0] b_y;
    logic       c_pe, c_hs, c_vs, c_hb, c_vb, c_act, c_ls, c_fs;
    logic [3:0] c_x;
    logic [2:0] c_y;
    logic       d_pe, d_hs, d_vs, d_hb, d_vb, d_act, d_ls, d_fs;
    logic [9:0] d_x;
    logic [9:0] d_y;

    vga_timing_gen #(.PIXEL_DIV(1), .H_AREA(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_AREA(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_a (
        .CLK_40(CLK_40), .reset_n(reset_n), .run(run), .pixel_en(a_pe), .x_pos(a_x), .y_pos(a_y),
        .hsync(a_hs), .vsync(a_vs), .h_blank(a_hb), .v_blank(a_vb), .active(a_act),
        .line_start(a_ls), .frame_start(a_fs));

    vga_timing_gen #(.PIXEL_DIV(3), .H_AREA(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_AREA(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_b (
        .CLK_40(CLK_40), .reset_n(reset_n), .run(run), .pixel_en(b_pe), .x_pos(b_x), .y_pos(b_y),
        .hsync(b_hs), .vsync(b_vs), .h_blank(b_hb), .v_blank(b_vb), .active(b_act),
        .line_start(b_ls), .frame_start(b_fs));

    vga_timing_gen #(.PIXEL_DIV(1), .H_AREA(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_AREA(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_c (
        .CLK_40(CLK_40), .reset_n(reset_n), .run(run), .pixel_en(c_pe), .x_pos(c_x), .y_pos(c_y),
        .hsync(c_hs), .vsync(c_vs), .h_blank(c_hb), .v_blank(c_vb), .active(c_act),
        .line_start(c_ls), .frame_start(c_fs));

    vga_timing_gen u_d (
        .CLK_40(CLK_40), .reset_n(reset_n), .run(run), .pixel_en(d_pe), .x_pos(d_x), .y_pos(d_y),
        .hsync(d_hs), .vsync(d_vs), .h_blank(d_hb), .v_blank(d_vb), .active(d_act),
        .line_start(d_ls), .frame_start(d_fs));

    task automatic tick();
        @(posedge CLK_40);
        #1;
    endtask

    // Reset, then raise run; returns at the first cycle that shows pixel (0,0)
    task automatic start_run();
        run = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        run = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [14:0] got, exp;
        run = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        got = {a_pe, a_x, a_y, a_hs, a_vs, a_hb, a_vb, a_act, a_ls, a_fs};
        exp = {1'b0, 4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_idle_a: got %h expected %h", got, exp);
        end
        n_cmp++;
        if ({c_hs, c_vs, c_pe} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_idle_c_sync: got %b expected 000", {c_hs, c_vs, c_pe});
        end
        n_cmp++;
        if ({b_pe, b_x, b_y, d_x, d_y, d_hb, d_vb} !== {1'b0, 4'd0, 3'd0, 10'd0, 10'd0, 2'b11}) begin
            n_err++;
            $display("FAIL reset_idle_bd: b_x %0d b_y %0d d_x %0d d_y %0d expected zeros",
                     b_x, b_y, d_x, d_y);
        end
    endtask

    task automatic test_startup();
        run = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        run = 1'b1;
        tick();
        n_cmp++;
        if ({a_pe, a_hb, a_act, a_fs} !== 4'b0100) begin
            n_err++;
            $display("FAIL startup_runq_cycle: got %b expected 0100", {a_pe, a_hb, a_act, a_fs});
        end
        tick();
        n_cmp++;
        if ({a_pe, a_x, a_y, a_act, a_ls, a_fs} !== {1'b1, 4'd0, 3'd0, 3'b111}) begin
            n_err++;
            $display("FAIL startup_first_a: got %h expected %h",
                     {a_pe, a_x, a_y, a_act, a_ls, a_fs}, {1'b1, 4'd0, 3'd0, 3'b111});
        end
        n_cmp++;
        if ({b_pe, b_x, b_act, b_fs} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL startup_first_b: got %h expected %h", {b_pe, b_x, b_act, b_fs}, 7'h02);
        end
        tick();
        tick();
        n_cmp++;
        if ({b_pe, b_x, b_fs} !== {1'b1, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL startup_div3_strobe: got %h expected %h", {b_pe, b_x, b_fs}, 6'h21);
        end
    endtask

    task automatic test_small_timing();
        logic [14:0] got, exp;
        logic [1:0]  cgot, cexp;
        int ex, ey, last_fs, n_fs;
        last_fs = -1;
        n_fs = 0;
        start_run();
        for (int cyc = 0; cyc < 300; cyc++) begin
            ex = cyc % 16;
            ey = (cyc / 16) % 8;
            exp = {1'b1, 4'(ex), 3'(ey),
                   !(ex >= 10 && ex <= 12), !(ey >= 5 && ey <= 6),
                   ex >= 8, ey >= 4, (ex < 8) && (ey < 4),
                   ex == 0, (ex == 0) && (ey == 0)};
            got = {a_pe, a_x, a_y, a_hs, a_vs, a_hb, a_vb, a_act, a_ls, a_fs};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL small_raster cyc %0d: got %h expected %h", cyc, got, exp);
            end
            cexp = {(ex >= 10 && ex <= 12), (ey >= 5 && ey <= 6)};
            cgot = {c_hs, c_vs};
            n_cmp++;
            if (cgot !== cexp) begin
                n_err++;
                $display("FAIL pol1_sync cyc %0d: got %b expected %b", cyc, cgot, cexp);
            end
            if (a_fs === 1'b1) begin
                n_fs++;
                if (last_fs >= 0) begin
                    n_cmp++;
                    if (cyc - last_fs !== 128) begin
                        n_err++;
                        $display("FAIL frame_period_div1: got %0d expected 128", cyc - last_fs);
                    end
                end
                last_fs = cyc;
            end
            tick();
        end
        n_cmp++;
        if (n_fs !== 3) begin
            n_err++;
            $display("FAIL frame_count_div1: got %0d expected 3", n_fs);
        end
    endtask

    task automatic test_pixel_div();
        logic [8:0] got, exp;
        int p, ex, ey, last_fs, n_fs;
        logic epe;
        last_fs = -1;
        n_fs = 0;
        start_run();
        for (int cyc = 0; cyc < 800; cyc++) begin
            p = cyc / 3;
            ex = p % 16;
            ey = (p / 16) % 8;
            epe = (cyc % 3) == 2;
            exp = {epe, 4'(ex), 3'(ey), epe && ex == 0 && ey == 0};
            got = {b_pe, b_x, b_y, b_fs};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL div3_raster cyc %0d: got %h expected %h", cyc, got, exp);
            end
            if (b_fs === 1'b1) begin
                n_fs++;
                if (last_fs >= 0) begin
                    n_cmp++;
                    if (cyc - last_fs !== 384) begin
                        n_err++;
                        $display("FAIL frame_period_div3: got %0d expected 384", cyc - last_fs);
                    end
                end
                last_fs = cyc;
            end
            tick();
        end
        n_cmp++;
        if (n_fs !== 3) begin
            n_err++;
            $display("FAIL frame_count_div3: got %0d expected 3", n_fs);
        end
    endtask

    task automatic test_run_stop();
        logic [14:0] got, exp;
        int waited;
        start_run();
        repeat (37) tick();
        n_cmp++;
        if ({a_x, a_y} !== {4'd5, 3'd2}) begin
            n_err++;
            $display("FAIL stop_position: got x %0d y %0d expected x 5 y 2", a_x, a_y);
        end
        run = 1'b0;
        tick();
        n_cmp++;
        if (a_x !== 4'd6) begin
            n_err++;
            $display("FAIL stop_last_advance: got x %0d expected 6", a_x);
        end
        tick();
        got = {a_pe, a_x, a_y, a_hs, a_vs, a_hb, a_vb, a_act, a_ls, a_fs};
        exp = {1'b0, 4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL stop_idle_a: got %h expected %h", got, exp);
        end
        n_cmp++;
        if ({c_hs, c_vs, b_x, b_y} !== {2'b00, 4'd0, 3'd0}) begin
            n_err++;
            $display("FAIL stop_idle_bc: got %h expected 000", {c_hs, c_vs, b_x, b_y});
        end
        run = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({a_pe, a_fs, a_x, a_y} !== {2'b11, 4'd0, 3'd0}) begin
            n_err++;
            $display("FAIL restart_first_a: got %h expected %h", {a_pe, a_fs, a_x, a_y}, 9'h180);
        end
        waited = 0;
        while (b_pe !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (waited !== 2 || b_fs !== 1'b1) begin
            n_err++;
            $display("FAIL restart_first_b: waited %0d fs %b expected 2 and 1", waited, b_fs);
        end
    endtask

    task automatic test_async_reset();
        start_run();
        repeat (11) tick();
        n_cmp++;
        if ({a_x, a_hs, c_hs} !== {4'd11, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL pre_reset_hsync: got x %0d hs %b c_hs %b expected 11 0 1", a_x, a_hs, c_hs);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_hs, c_hs, a_hb, a_pe} !== 4'b1010) begin
            n_err++;
            $display("FAIL async_reset_flags: got %b expected 1010", {a_hs, c_hs, a_hb, a_pe});
        end
        n_cmp++;
        if ({a_x, a_y, b_x, b_y, d_x, d_y} !== '0) begin
            n_err++;
            $display("FAIL async_reset_counters: a %0d/%0d b %0d/%0d d %0d/%0d expected zeros",
                     a_x, a_y, b_x, b_y, d_x, d_y);
        end
        run = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_default();
        logic [22:0] got, exp;
        int ex, ey, act_cnt, last_ls;
        act_cnt = 0;
        last_ls = -1;
        start_run();
        for (int cyc = 0; cyc < 1800; cyc++) begin
            ex = cyc % 800;
            ey = cyc / 800;
            exp = {10'(ex), 10'(ey), ex == 0, !(ex >= 656 && ex < 752), 1'b0};
            got = {d_x, d_y, d_ls, d_hs, d_vb};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL vga640_raster cyc %0d: got %h expected %h", cyc, got, exp);
            end
            if (d_act === 1'b1) act_cnt++;
            if (ex == 799) begin
                n_cmp++;
                if (act_cnt !== 640) begin
                    n_err++;
                    $display("FAIL vga640_active_per_line line %0d: got %0d expected 640", ey, act_cnt);
                end
                act_cnt = 0;
            end
            if (d_ls === 1'b1) begin
                if (last_ls >= 0) begin
                    n_cmp++;
                    if (cyc - last_ls !== 800) begin
                        n_err++;
                        $display("FAIL vga640_line_period: got %0d expected 800", cyc - last_ls);
                    end
                end
                last_ls = cyc;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_small_timing();
        test_pixel_div();
        test_run_stop();
        test_async_reset();
        test_default();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter PIXEL_DIV, default 1, meaning CLK_40 cycles per pixel (>=1).
REQ-002 SHALL have parameters H_AREA 640, H_FP 16, H_SYNC 96, H_BP 48, meaning horizontal active, front porch, sync and back porch lengths in pixels.
REQ-003 SHALL have parameters V_AREA 480, V_FP 10, V_SYNC 2, V_BP 33, meaning vertical active, front porch, sync and back porch lengths in lines.
REQ-004 SHALL have parameters HSYNC_POL 0 and VSYNC_POL 0, meaning the asserted sync level (0 = active-low).
REQ-005 CLK_40  in  1  system clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 run  in  1  timing enable; low holds the generator idle.
REQ-008 pixel_en  out  1  one-cycle pixel strobe.
REQ-009 x_pos  out  X_W  current pixel column, where X_W = $clog2(H_TOTAL).
REQ-010 y_pos  out  Y_W  current line, where Y_W = $clog2(V_TOTAL).
REQ-011 hsync, vsync  out  1 each  sync outputs at the parametrised polarity.
REQ-012 h_blank, v_blank, active  out  1 each  blanking flags; active = neither blank.
REQ-013 line_start, frame_start  out  1 each  one-cycle markers.

Function
REQ-014 H_TOTAL SHALL equal H_AREA+H_FP+H_SYNC+H_BP; V_TOTAL SHALL equal V_AREA+V_FP+V_SYNC+V_BP.
REQ-015 A divider SHALL count 0..PIXEL_DIV-1 while run_q=1; pixel_en SHALL be 1 when the divider equals PIXEL_DIV-1. With PIXEL_DIV=1, pixel_en SHALL be held 1 while running.
REQ-016 x_pos SHALL advance on each clock edge where pixel_en=1, wrapping from H_TOTAL-1 to 0.
REQ-017 y_pos SHALL advance when x_pos wraps, wrapping from V_TOTAL-1 to 0.
REQ-018 hsync SHALL equal HSYNC_POL exactly when H_AREA+H_FP <= x_pos < H_AREA+H_FP+H_SYNC, and ~HSYNC_POL otherwise.
REQ-019 vsync SHALL equal VSYNC_POL exactly when V_AREA+V_FP <= y_pos < V_AREA+V_FP+V_SYNC, and ~VSYNC_POL otherwise.
REQ-020 h_blank SHALL be 1 when x_pos >= H_AREA; v_blank SHALL be 1 when y_pos >= V_AREA.
REQ-021 All outputs SHALL be registered, and hsync/vsync/blank/active SHALL describe the x_pos/y_pos values presented in the same cycle, with zero skew.
REQ-022 line_start SHALL be 1 when pixel_en=1 and x_pos=0; frame_start SHALL be 1 when line_start=1 and y_pos=0.
REQ-023 run SHALL be registered into run_q, adding one cycle of latency.
REQ-024 While run_q=0, the outputs SHALL be:
- divider, x_pos and y_pos held at 0;
- pixel_en 0;
- syncs inactive;
- h_blank=v_blank=1, active 0;
- markers 0.
REQ-025 On the cycle after run_q rises, outputs SHALL describe (0,0); the first pixel_en SHALL follow PIXEL_DIV-1 cycles later, and this first strobe SHALL carry frame_start=1.
REQ-026 run falling mid-frame SHALL force the idle state of REQ-024 on the cycle after run_q falls, with no partial-line completion.

Reset
REQ-027 reset_n low SHALL asynchronously force run_q=0 and the idle output values of REQ-024.
REQ-028 Release of reset_n SHALL be followed by normal REQ-023 behaviour; no output SHALL glitch to an active level during reset.

Structure
REQ-029 A shared package vga_pkg SHALL hold the default 640x480 timing constants and a timing-parameter struct typedef.
REQ-030 The pixel divider SHALL be one sub-module, pixel_en_div, parametrised by PIXEL_DIV and carrying the run-qualified enable.

Verification
REQ-031 Small-config bench:
- parameters: PIXEL_DIV=1, H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), polarities 0;
- required: hsync=0 for x=10..12 only; vsync=0 for y=5..6 only; frame_start period = 128 cycles.
REQ-032 Same config with PIXEL_DIV=3:
- required: pixel_en period = 3 cycles; x_pos stable across each 3-cycle group; frame_start period = 384 cycles.
REQ-033 HSYNC_POL=1 and VSYNC_POL=1:
- required: hsync=1 for x=10..12 and vsync=1 for y=5..6; idle levels are 0.
REQ-034 Deassert run at x=5, y=2:
- required: after 2 cycles, x=y=0, h_blank=v_blank=1, syncs inactive;
- on reassert: the first pixel_en carries frame_start.
REQ-035 Assert reset_n=0 asynchronously mid-hsync (x=11):
- required: hsync returns to the inactive level before the next clock edge and all counters read 0.
REQ-036 Default 640x480 config with PIXEL_DIV=1:
- required: line_start period = 800 pixels; active count per frame = 307200.
